packet_filter: RTL and testbench
================================

PACKET_FILTER -- requirements
Module: packet_filter

Interface
Parameters (name, default, meaning):
REQ-001 SHALL have parameter BLOCK_IP0, 32'hC0A80164 (192.168.1.100): blocked source IP entry 0.
REQ-002 SHALL have parameter BLOCK_IP1, 32'h0A00000A: blocked entry 1.
REQ-003 SHALL have parameter BLOCK_IP2, 32'hAC100001: blocked entry 2.
REQ-004 SHALL have parameter BLOCK_IP3, 32'h00000000: blocked entry 3; any entry equal to 0 is disabled and never matches.
REQ-005 SHALL have parameter SRC_IP_OFFSET, 26: byte index of the first source-IP byte (14-byte Ethernet header + IPv4 offset 12).
Ports (name, direction, width, meaning):
REQ-006 SHALL have port clk, input, 1: sole clock; all state changes on rising edge.
REQ-007 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port data_in, input, 8: packet byte, first byte first.
REQ-009 SHALL have port valid_in, input, 1: data_in holds a packet byte this cycle.
REQ-010 SHALL have port packet_allowed, output, 1: decision for the last completed packet (1 = allow, 0 = block).
REQ-011 SHALL have port done, output, 1: one-cycle pulse marking a valid decision.

Function
REQ-012 SHALL accept one byte on each rising clk edge where valid_in=1; a packet is a maximal run of consecutive valid_in=1 cycles.
REQ-013 SHALL keep a 16-bit byte counter: 0 at packet start, +1 per accepted byte, saturating at 16'hFFFF.
REQ-014 SHALL capture bytes at indices SRC_IP_OFFSET..SRC_IP_OFFSET+3 into a 32-bit src_ip register, big-endian (first byte = bits 31:24).
REQ-015 SHALL use FSM states IDLE, RECV, DECIDE.
REQ-016 IDLE: valid_in=1 -> accept byte 0, go RECV; otherwise stay.
REQ-017 RECV: valid_in=1 -> accept byte, stay; valid_in=0 -> go DECIDE (packet ended).
REQ-018 DECIDE (exactly one cycle): register packet_allowed and set done=1 on the edge leaving DECIDE; next state IDLE, or RECV if valid_in=1 in DECIDE, in which case that byte is byte 0 of the next packet.
REQ-019 Latency: done rises on the 2nd rising edge after the first valid_in=0 edge following a packet.
REQ-020 SHALL set packet_allowed=0 if src_ip equals any enabled BLOCK_IPn.
REQ-021 SHALL set packet_allowed=0 if fewer than SRC_IP_OFFSET+4 bytes were received (incomplete header); done still pulses.
REQ-022 SHALL otherwise set packet_allowed=1; bytes after the source IP are ignored.
REQ-023 done SHALL be high for exactly one clock per packet, registered, never asserted in IDLE/RECV without a completed packet.
REQ-024 packet_allowed SHALL be valid when done=1 and hold until the next decision.
REQ-025 src_ip and byte counter SHALL clear at each packet start, so no state leaks between packets.

Reset
REQ-026 rst=0 SHALL immediately force state IDLE, byte counter 0, src_ip 0, done=0, packet_allowed=0.
REQ-027 A packet interrupted by reset SHALL be discarded with no done pulse; after rst returns to 1, the next valid_in=1 byte starts a new packet.

Verification
REQ-028 40-byte packet, zeros except bytes 26-29 = C0 A8 01 64 -> single done pulse, packet_allowed=0.
REQ-029 40-byte packet with bytes 26-29 = C0 A8 01 65 -> done pulse, packet_allowed=1.
REQ-030 20-byte packet -> done pulse, packet_allowed=0.
REQ-031 Packet src 0A 00 00 0A then, after one idle cycle, packet src 08 08 08 08 -> two done pulses with packet_allowed 0 then 1.
REQ-032 40-byte blocked packet with rst=0 after byte 27, then 40-byte packet src 01 02 03 04 -> no done for the first, one done with packet_allowed=1 for the second.
REQ-033 Packet src 00 00 00 00 (BLOCK_IP3 disabled) -> packet_allowed=1.

Source files
------------

// File: rtl/packet_filter.sv
// Streaming source-IP filter: collects one packet byte per valid cycle, grabs the
// IPv4 source address and issues an allow/block decision one cycle after the packet ends.
module packet_filter #(
  parameter logic [31:0] BLOCK_IP0     = 32'hC0A80164,
  parameter logic [31:0] BLOCK_IP1     = 32'h0A00000A,
  parameter logic [31:0] BLOCK_IP2     = 32'hAC100001,
  parameter logic [31:0] BLOCK_IP3     = 32'h00000000,
  parameter int          SRC_IP_OFFSET = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       packet_allowed,
  output logic       done
);

  localparam int NUM_ENTRIES = 4;
  localparam logic [15:0] IP_LO   = 16'(SRC_IP_OFFSET);
  localparam logic [15:0] IP_HI   = 16'(SRC_IP_OFFSET + 3);
  localparam logic [15:0] MIN_LEN = 16'(SRC_IP_OFFSET + 4);
  localparam logic [NUM_ENTRIES-1:0][31:0] BLOCK_TBL =
    {BLOCK_IP3, BLOCK_IP2, BLOCK_IP1, BLOCK_IP0};

  typedef enum logic [1:0] {IDLE, RECV, DECIDE} state_t;

  state_t      state, state_nxt;
  logic [15:0] byte_cnt, byte_cnt_nxt, idx;
  logic [31:0] src_ip, src_ip_nxt;
  logic [1:0]  lane;
  logic        start, in_ip, allow;
  logic [NUM_ENTRIES-1:0] hit;

  // A zero table entry is disabled, so an all-zero source address can never be blocked by it.
  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_match
    assign hit[g] = (BLOCK_TBL[g] != 32'd0) && (src_ip == BLOCK_TBL[g]);
  end

  assign allow = (byte_cnt >= MIN_LEN) && !(|hit);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid_in)  state_nxt = RECV;
      RECV:    if (!valid_in) state_nxt = DECIDE;
      DECIDE:  state_nxt = valid_in ? RECV : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Any valid byte outside RECV opens a new packet, including one arriving during DECIDE.
  always_comb begin
    start        = valid_in && (state != RECV);
    idx          = start ? 16'd0 : byte_cnt;
    in_ip        = (idx >= IP_LO) && (idx <= IP_HI);
    lane         = 2'(idx - IP_LO);
    byte_cnt_nxt = byte_cnt;
    src_ip_nxt   = src_ip;
    if (start) begin
      byte_cnt_nxt = 16'd1;
      src_ip_nxt   = 32'd0;
    end else if (valid_in && byte_cnt != 16'hFFFF) begin
      byte_cnt_nxt = byte_cnt + 16'd1;
    end
    if (valid_in && in_ip)
      src_ip_nxt[{~lane, 3'b000} +: 8] = data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      byte_cnt       <= 16'd0;
      src_ip         <= 32'd0;
      done           <= 1'b0;
      packet_allowed <= 1'b0;
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
      src_ip   <= src_ip_nxt;
      done     <= (state == DECIDE);
      if (state == DECIDE)
        packet_allowed <= allow;
    end
  end

endmodule

// File: tb/tb_packet_filter.sv
// Directed bench for packet_filter: decision timing, blocklist hits, short packets,
// back-to-back packets and mid-packet reset.
module tb_packet_filter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       packet_allowed;
  logic       done;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  logic allow_q[$];

  packet_filter dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .packet_allowed(packet_allowed), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (done) begin
      done_cnt = done_cnt + 1;
      allow_q.push_back(packet_allowed);
    end
  end

  // Returns on the negedge where valid_in has just dropped (before the ending edge).
  task automatic send_pkt(input int len, input logic [31:0] ip);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      valid_in = 1'b1;
      data_in  = (i >= 26 && i <= 29) ? ip[8*(29-i) +: 8] : 8'h00;
    end
    @(negedge clk);
    valid_in = 1'b0;
    data_in  = 8'h00;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (packet_allowed !== 1'b0) begin bad++; $display("FAIL reset_allow got=%b want=0", packet_allowed); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (done_cnt !== 0) begin bad++; $display("FAIL reset_no_pulse got=%0d want=0", done_cnt); end
  endtask

  // Decision must appear exactly on the second edge after valid_in drops, for one cycle, then hold.
  task automatic test_packet(input string name, input int len, input logic [31:0] ip, input logic exp);
    int c0;
    c0 = done_cnt;
    send_pkt(len, ip);
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL %s_early got=%b want=0", name, done); end
    @(negedge clk);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL %s_done got=%b want=1", name, done); end
    total++; if (packet_allowed !== exp) begin bad++; $display("FAIL %s_allow got=%b want=%b", name, packet_allowed, exp); end
    repeat (2) @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL %s_pulse_len got=%b want=0", name, done); end
    total++; if (packet_allowed !== exp) begin bad++; $display("FAIL %s_hold got=%b want=%b", name, packet_allowed, exp); end
    total++; if (done_cnt !== c0 + 1) begin bad++; $display("FAIL %s_count got=%0d want=%0d", name, done_cnt - c0, 1); end
  endtask

  task automatic test_back_to_back;
    allow_q.delete();
    send_pkt(40, 32'h0A00000A);
    send_pkt(40, 32'h08080808);
    repeat (4) @(negedge clk);
    total++; if (allow_q.size() !== 2) begin bad++; $display("FAIL b2b_pulses got=%0d want=2", allow_q.size()); end
    else begin
      total++; if (allow_q[0] !== 1'b0) begin bad++; $display("FAIL b2b_first got=%b want=0", allow_q[0]); end
      total++; if (allow_q[1] !== 1'b1) begin bad++; $display("FAIL b2b_second got=%b want=1", allow_q[1]); end
    end
  endtask

  task automatic test_reset_mid;
    int c0;
    logic [31:0] ip = 32'hC0A80164;
    c0 = done_cnt;
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      valid_in = 1'b1;
      data_in  = (i >= 26) ? ip[8*(29-i) +: 8] : 8'h00;
    end
    @(negedge clk);
    valid_in = 1'b0;
    data_in  = 8'h00;
    rst = 1'b0;
    #1;
    total++; if (packet_allowed !== 1'b0) begin bad++; $display("FAIL rstmid_allow got=%b want=0", packet_allowed); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (done_cnt !== c0) begin bad++; $display("FAIL rstmid_no_done got=%0d want=0", done_cnt - c0); end
    test_packet("after_rst", 40, 32'h01020304, 1'b1);
  endtask

  initial begin
    test_reset;
    test_packet("blocked0", 40, 32'hC0A80164, 1'b0);
    test_packet("allowed", 40, 32'hC0A80165, 1'b1);
    test_packet("short20", 20, 32'h01020304, 1'b0);
    test_packet("short29", 29, 32'h01020304, 1'b0);
    test_packet("exact30", 30, 32'h01020304, 1'b1);
    test_packet("blocked2", 40, 32'hAC100001, 1'b0);
    test_packet("one_byte", 1, 32'h01020304, 1'b0);
    test_back_to_back;
    test_packet("allowed2", 40, 32'h08080808, 1'b1);
    test_reset_mid;
    test_packet("zero_ip", 40, 32'h00000000, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule
